// File: rtl/hasti_arbiter.sv
// hasti_arbiter: per-slave arbitration controller for the HASTI crossbar.
//   Picks which master's address phase reaches the slave. A master that loses
//   is captured into a holding register, stalled, and replayed later.
//   Keeps bursts and locked sequences together and is round-robin fair.
// Ports:
//   hclk, hresetn      clock, asynchronous active-low reset
//   htrans_i           live HTRANS per master, slice m = [2m+1:2m]
//   hmastlock_i        live HMASTLOCK per master
//   hready_i           HREADY from the slave
//   addr_sel_o         one-hot address-phase select, all-zero drives IDLE
//   use_hold_o         take master m's address from its holding register
//   capture_o          latch master m's live address into its holding register
//   data_sel_o         one-hot data-phase owner (steers HRDATA/HRESP)
//   hready_o           HREADY returned to each master
module hasti_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int MAX_HOLD  = 8
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    input  logic [2*N_MASTERS-1:0] htrans_i,
    input  logic [N_MASTERS-1:0]   hmastlock_i,
    input  logic                   hready_i,
    output logic [N_MASTERS-1:0]   addr_sel_o,
    output logic [N_MASTERS-1:0]   use_hold_o,
    output logic [N_MASTERS-1:0]   capture_o,
    output logic [N_MASTERS-1:0]   data_sel_o,
    output logic [N_MASTERS-1:0]   hready_o
);
    localparam int         IW         = $clog2(N_MASTERS);
    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    logic [N_MASTERS-1:0] pend_q, pend_d, owner_q, data_sel_q;
    logic [N_MASTERS-1:0] live_req, req, seq_busy, pick, gnt;
    logic [7:0]           hold_cnt_q, hold_cnt_d, cnt_base;
    logic [IW-1:0]        rr_q, rr_d;
    logic                 lock_q, lock_d, keep, other_req, chg;

    always_comb begin
        live_req = '0;
        seq_busy = '0;
        for (int m = 0; m < N_MASTERS; m++) begin
            live_req[m] = htrans_i[2*m+1] & ~pend_q[m];
            seq_busy[m] = htrans_i[2*m];
        end
        req  = live_req | pend_q;
        // Bursts and locked sequences override the fairness limit.
        keep = |(owner_q & req) & (|(owner_q & seq_busy) | lock_q |
               (hold_cnt_q < MAX_HOLD_C) | ~|(req & ~owner_q));
        // Walk downwards so the nearest requester after rr_q wins.
        pick = '0;
        for (int k = N_MASTERS; k >= 1; k--) begin
            int idx;
            idx = (int'(rr_q) + k) % N_MASTERS;
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        gnt        = keep ? owner_q : pick;
        addr_sel_o = gnt & req;
        use_hold_o = addr_sel_o & pend_q;
        hready_o   = ~pend_q & (~data_sel_q | {N_MASTERS{hready_i}});
        capture_o  = live_req & ~addr_sel_o & hready_o;
        data_sel_o = data_sel_q;
        other_req  = |(req & ~addr_sel_o);
        chg        = addr_sel_o != owner_q;
        cnt_base   = chg ? 8'd0 : hold_cnt_q;
        hold_cnt_d = (|addr_sel_o & other_req & (cnt_base < MAX_HOLD_C)) ? cnt_base + 8'd1 : cnt_base;
        // The pointer only ever needs to follow the owner, so tracking the
        // current grant is identical to updating it on grant changes.
        rr_d = rr_q;
        for (int m = 0; m < N_MASTERS; m++)
            if (addr_sel_o[m]) rr_d = IW'(m);
        lock_d = |(addr_sel_o & hmastlock_i);
        // A capture is qualified by hready_o, so the master has seen its
        // address accepted; the pending flag must stick even while the slave
        // stalls. Replays only retire when the slave accepts them.
        pend_d = (pend_q | capture_o) & ~(use_hold_o & {N_MASTERS{hready_i}});
    end

    // A granted master always carries NONSEQ/SEQ (live request bit or a
    // captured request), so the data-phase owner is simply the address grant.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            pend_q     <= '0;
            owner_q    <= '0;
            data_sel_q <= '0;
            hold_cnt_q <= '0;
            rr_q       <= IW'(N_MASTERS - 1);
            lock_q     <= 1'b0;
        end else begin
            pend_q <= pend_d;
            if (hready_i) begin
                owner_q    <= addr_sel_o;
                data_sel_q <= addr_sel_o;
                hold_cnt_q <= hold_cnt_d;
                rr_q       <= rr_d;
                lock_q     <= lock_d;
            end
        end
    end
endmodule
